// File: rtl/systolic_pkg.sv
// Shared constants and FSM state encoding for the systolic feeder.
// Imported by the feeder top and its lane delay sub-module.
package systolic_pkg;

   localparam int ARRAY_DIM = 4;
   localparam int DATA_W    = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/skew_delay.sv
// Per-lane delay line of DEPTH registers with synchronous flush.
// DEPTH=0 is a plain wire so lane 0 needs no special casing.
module skew_delay #(
   parameter int DEPTH = 1,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   if (DEPTH == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst_n, clear};
      assign q_o = d_i;
   end else begin : g_pipe
      logic [W-1:0] pipe_q [DEPTH];

      // shift one stage per cycle; clear flushes the whole line
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int n = 0; n < DEPTH; n++) pipe_q[n] <= '0;
         end else if (clear) begin
            for (int n = 0; n < DEPTH; n++) pipe_q[n] <= '0;
         end else begin
            pipe_q[0] <= d_i;
            for (int n = 1; n < DEPTH; n++) pipe_q[n] <= pipe_q[n-1];
         end
      end

      assign q_o = pipe_q[DEPTH-1];
   end

endmodule

// File: rtl/systolic_feeder.sv
// Streams K words of A/B through skewed lanes into a 4x4 PE array.
// Optional FEEDER_PERF_CNT_EN adds a per-tile busy cycle counter.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [15:0]       k_len,
   output logic              a_ren,
   output logic              b_ren,
   output logic [ADDR_W-1:0] a_addr,
   output logic [ADDR_W-1:0] b_addr,
   input  logic [31:0]       a_rdata,
   input  logic [31:0]       b_rdata,
   output logic              pe_clear,
   output logic              pe_valid,
   output logic [7:0]        pe_a0,
   output logic [7:0]        pe_a1,
   output logic [7:0]        pe_a2,
   output logic [7:0]        pe_a3,
   output logic [7:0]        pe_b0,
   output logic [7:0]        pe_b1,
   output logic [7:0]        pe_b2,
   output logic [7:0]        pe_b3,
   output logic              busy,
   output logic              done,
   output logic [31:0]       perf_cycles
);

   state_e      state_q, state_d;
   logic [16:0] cyc_q, cyc_d;
   logic [15:0] k_q, k_d;
   logic [16:0] kx;
   logic        rvalid_q;
   logic [31:0] a_cap_q, b_cap_q;
   logic        ren;
   logic        accept;

   logic [DATA_W-1:0] a_lane [ARRAY_DIM];
   logic [DATA_W-1:0] b_lane [ARRAY_DIM];

   assign kx     = {1'b0, k_q};
   assign accept = (state_q == IDLE) && start && !abort;

   // tile sequencing; cyc counts cycles since start acceptance
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      k_d     = k_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = CLEAR;
               cyc_d   = 17'd1;
               k_d     = k_len;
            end
         end
         CLEAR: begin
            cyc_d = cyc_q + 17'd1;
            if (k_q == 16'd0)        state_d = DONE;
            else if (cyc_q == 17'd2) state_d = FEED;
         end
         FEED: begin
            cyc_d = cyc_q + 17'd1;
            if (cyc_q == kx + 17'd5) state_d = DRAIN;
         end
         DRAIN: begin
            cyc_d = cyc_q + 17'd1;
            if (cyc_q == kx + 17'd9) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            cyc_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cyc_d   = '0;
         end
      endcase
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         cyc_d   = '0;
      end
   end

   // FSM and tile parameter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         k_q     <= k_d;
      end
   end

   assign busy     = (state_q == CLEAR) || (state_q == FEED)
                  || (state_q == DRAIN);
   assign pe_valid = (state_q == FEED) || (state_q == DRAIN);
   assign pe_clear = (state_q == CLEAR) && (cyc_q == 17'd1);
   assign done     = (state_q == DONE);

   assign ren    = busy && (cyc_q <= kx);
   assign a_ren  = ren;
   assign b_ren  = ren;
   assign a_addr = ren ? ADDR_W'(cyc_q - 17'd1) : '0;
   assign b_addr = a_addr;

   // capture read data one cycle after the strobe; zero otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         a_cap_q  <= '0;
         b_cap_q  <= '0;
      end else if (abort) begin
         rvalid_q <= 1'b0;
         a_cap_q  <= '0;
         b_cap_q  <= '0;
      end else begin
         rvalid_q <= ren;
         a_cap_q  <= rvalid_q ? a_rdata : '0;
         b_cap_q  <= rvalid_q ? b_rdata : '0;
      end
   end

   for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
      skew_delay #(.DEPTH(i), .W(DATA_W)) u_skew_a (
         .clk   (clk),
         .rst_n (rst_n),
         .clear (abort),
         .d_i   (a_cap_q[i*DATA_W +: DATA_W]),
         .q_o   (a_lane[i])
      );
      skew_delay #(.DEPTH(i), .W(DATA_W)) u_skew_b (
         .clk   (clk),
         .rst_n (rst_n),
         .clear (abort),
         .d_i   (b_cap_q[i*DATA_W +: DATA_W]),
         .q_o   (b_lane[i])
      );
   end

   assign pe_a0 = a_lane[0];
   assign pe_a1 = a_lane[1];
   assign pe_a2 = a_lane[2];
   assign pe_a3 = a_lane[3];
   assign pe_b0 = b_lane[0];
   assign pe_b1 = b_lane[1];
   assign pe_b2 = b_lane[2];
   assign pe_b3 = b_lane[3];

`ifdef FEEDER_PERF_CNT_EN
   logic [31:0] perf_q;

   // busy cycle count; holds after done until the next start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        perf_q <= '0;
      else if (abort && state_q != IDLE) perf_q <= '0;
      else if (accept)                   perf_q <= '0;
      else if (busy)                     perf_q <= perf_q + 32'd1;
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a buffer and PE array model.
// Perf expectations follow FEEDER_PERF_CNT_EN.
module tb_systolic_feeder;

`ifdef FEEDER_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] k_len;
   logic        a_ren, b_ren;
   logic [15:0] a_addr, b_addr;
   logic [31:0] a_rdata, b_rdata;
   logic        pe_clear, pe_valid, busy, done;
   logic [7:0]  pe_a0, pe_a1, pe_a2, pe_a3;
   logic [7:0]  pe_b0, pe_b1, pe_b2, pe_b3;
   logic [31:0] perf_cycles;

   logic [31:0] amem [16];
   logic [31:0] bmem [16];

   int errs   = 0;
   int checks = 0;

   logic [63:0] m_clr, m_busy, m_val, m_done, m_ren;
   logic [7:0]  lg_a [64][4];
   logic [7:0]  lg_b [64][4];
   logic [15:0] lg_addr [64];
   logic [31:0] lg_perf [64];

   always #5 clk = ~clk;

   // buffer model with 1-cycle read latency; junk when not read
   always @(posedge clk) begin
      a_rdata <= a_ren ? amem[a_addr[3:0]] : 32'hDEADBEEF;
      b_rdata <= b_ren ? bmem[b_addr[3:0]] : 32'hDEADBEEF;
   end

   systolic_feeder #(.ADDR_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .k_len       (k_len),
      .a_ren       (a_ren),
      .b_ren       (b_ren),
      .a_addr      (a_addr),
      .b_addr      (b_addr),
      .a_rdata     (a_rdata),
      .b_rdata     (b_rdata),
      .pe_clear    (pe_clear),
      .pe_valid    (pe_valid),
      .pe_a0       (pe_a0),
      .pe_a1       (pe_a1),
      .pe_a2       (pe_a2),
      .pe_a3       (pe_a3),
      .pe_b0       (pe_b0),
      .pe_b1       (pe_b1),
      .pe_b2       (pe_b2),
      .pe_b3       (pe_b3),
      .busy        (busy),
      .done        (done),
      .perf_cycles (perf_cycles)
   );

   function automatic logic [63:0] bits(input int lo, input int hi);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 64; i++) if (i >= lo && i <= hi) m[i] = 1'b1;
      return m;
   endfunction

   // PE(i,j) sees a lane i delayed by j and b lane j delayed by i
   function automatic int cval(input int i, input int j);
      int acc;
      acc = 0;
      for (int t = 0; t < 64; t++) begin
         if (t >= i && t >= j)
            acc += int'($signed(lg_a[t-j][i])) * int'($signed(lg_b[t-i][j]));
      end
      return acc;
   endfunction

   // cycle 0 is the current cycle; logs cycles 0..n
   task automatic run_tile(input int k, input int n,
                           input int ab, input int rs);
      m_clr = '0; m_busy = '0; m_val = '0; m_done = '0; m_ren = '0;
      for (int c = 0; c < 64; c++) begin
         for (int l = 0; l < 4; l++) begin
            lg_a[c][l] = '0;
            lg_b[c][l] = '0;
         end
         lg_addr[c] = '0;
         lg_perf[c] = '0;
      end
      for (int c = 0; c <= n; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         m_clr[c]  = pe_clear;
         m_busy[c] = busy;
         m_val[c]  = pe_valid;
         m_done[c] = done;
         m_ren[c]  = a_ren;
         lg_a[c][0] = pe_a0; lg_a[c][1] = pe_a1;
         lg_a[c][2] = pe_a2; lg_a[c][3] = pe_a3;
         lg_b[c][0] = pe_b0; lg_b[c][1] = pe_b1;
         lg_b[c][2] = pe_b2; lg_b[c][3] = pe_b3;
         lg_addr[c] = a_addr;
         lg_perf[c] = perf_cycles;
         start = (c == 0) || (c == rs);
         abort = (c == ab);
         k_len = 16'(k);
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({busy, done, pe_valid, pe_clear, a_ren, b_ren} !== 6'b0) begin
         errs++;
         $display("FAIL reset_ctrl got=%b exp=0",
                  {busy, done, pe_valid, pe_clear, a_ren, b_ren});
      end
      checks++;
      if ({pe_a0, pe_a3, pe_b0, pe_b3, perf_cycles} !== 64'h0) begin
         errs++;
         $display("FAIL reset_data got=%h exp=0",
                  {pe_a0, pe_a3, pe_b0, pe_b3, perf_cycles});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_k1();
      amem[0] = 32'h04030201;
      bmem[0] = 32'h01010101;
      run_tile(1, 14, -1, -1);
      checks++;
      if (m_clr !== bits(1, 1)) begin
         errs++; $display("FAIL k1_clear got=%h exp=%h", m_clr, bits(1, 1));
      end
      checks++;
      if (m_ren !== bits(1, 1)) begin
         errs++; $display("FAIL k1_ren got=%h exp=%h", m_ren, bits(1, 1));
      end
      checks++;
      if (m_busy !== bits(1, 10)) begin
         errs++; $display("FAIL k1_busy got=%h exp=%h", m_busy, bits(1, 10));
      end
      checks++;
      if (m_val !== bits(3, 10)) begin
         errs++; $display("FAIL k1_valid got=%h exp=%h", m_val, bits(3, 10));
      end
      checks++;
      if (m_done !== bits(11, 11)) begin
         errs++; $display("FAIL k1_done got=%h exp=%h", m_done, bits(11, 11));
      end
      checks++;
      if (lg_a[3][0] !== 8'h01) begin
         errs++; $display("FAIL k1_a0_c3 got=%h exp=01", lg_a[3][0]);
      end
      checks++;
      if (lg_a[6][3] !== 8'h04) begin
         errs++; $display("FAIL k1_a3_c6 got=%h exp=04", lg_a[6][3]);
      end
      checks++;
      if (lg_a[5][3] !== 8'h00 || lg_a[7][3] !== 8'h00) begin
         errs++;
         $display("FAIL k1_a3_edges got=%h,%h exp=00,00",
                  lg_a[5][3], lg_a[7][3]);
      end
      checks++;
      if (lg_b[5][2] !== 8'h01) begin
         errs++; $display("FAIL k1_b2_c5 got=%h exp=01", lg_b[5][2]);
      end
      checks++;
      if (lg_perf[11] !== (PERF ? 32'd10 : 32'd0)) begin
         errs++;
         $display("FAIL k1_perf got=%0d exp=%0d", lg_perf[11],
                  PERF ? 10 : 0);
      end
   endtask

   task automatic test_matmul();
      for (int k = 0; k < 4; k++) begin
         amem[k] = 32'h1 << (8 * k);
         bmem[k] = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
      end
      run_tile(4, 16, -1, -1);
      for (int t = 0; t < 4; t++) begin
         checks++;
         if (lg_addr[1+t] !== 16'(t)) begin
            errs++;
            $display("FAIL mm_addr%0d got=%0d exp=%0d", t, lg_addr[1+t], t);
         end
      end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (cval(i, j) !== 4*i+j+1) begin
               errs++;
               $display("FAIL mm_c%0d%0d got=%0d exp=%0d",
                        i, j, cval(i, j), 4*i+j+1);
            end
         end
      checks++;
      if (m_done !== bits(14, 14)) begin
         errs++; $display("FAIL mm_done got=%h exp=%h", m_done, bits(14, 14));
      end
   endtask

   task automatic test_signed();
      amem[0] = 32'h80808080; amem[1] = 32'h80808080;
      bmem[0] = 32'h80808080; bmem[1] = 32'h80808080;
      run_tile(2, 14, -1, -1);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (cval(i, j) !== 32768) begin
               errs++;
               $display("FAIL sgn_c%0d%0d got=%0d exp=32768",
                        i, j, cval(i, j));
            end
         end
   endtask

   task automatic test_k0();
      run_tile(0, 6, -1, -1);
      checks++;
      if (m_clr !== bits(1, 1)) begin
         errs++; $display("FAIL k0_clear got=%h exp=%h", m_clr, bits(1, 1));
      end
      checks++;
      if (m_done !== bits(2, 2)) begin
         errs++; $display("FAIL k0_done got=%h exp=%h", m_done, bits(2, 2));
      end
      checks++;
      if (m_ren !== 64'h0) begin
         errs++; $display("FAIL k0_ren got=%h exp=0", m_ren);
      end
      checks++;
      if (m_busy !== bits(1, 1) || m_val !== 64'h0) begin
         errs++;
         $display("FAIL k0_busy_valid got=%h,%h exp=%h,0",
                  m_busy, m_val, bits(1, 1));
      end
   endtask

   task automatic test_abort();
      logic [7:0] acc;
      for (int w = 0; w < 16; w++) begin
         amem[w] = 32'h01010101 * (w + 1);
         bmem[w] = 32'h02020202 * (w + 1);
      end
      run_tile(8, 12, 5, -1);
      checks++;
      if (lg_a[5][0] !== 8'h03) begin
         errs++; $display("FAIL ab_a0_c5 got=%h exp=03", lg_a[5][0]);
      end
      checks++;
      if (m_busy !== bits(1, 5) || m_val !== bits(3, 5)) begin
         errs++;
         $display("FAIL ab_busy_valid got=%h,%h exp=%h,%h",
                  m_busy, m_val, bits(1, 5), bits(3, 5));
      end
      checks++;
      if (m_done !== 64'h0 || m_ren !== bits(1, 5)) begin
         errs++;
         $display("FAIL ab_done_ren got=%h,%h exp=0,%h",
                  m_done, m_ren, bits(1, 5));
      end
      acc = '0;
      for (int c = 6; c <= 12; c++)
         for (int l = 0; l < 4; l++) acc |= lg_a[c][l] | lg_b[c][l];
      checks++;
      if (acc !== 8'h00) begin
         errs++; $display("FAIL ab_bytes_zero got=%h exp=00", acc);
      end
      checks++;
      if (lg_perf[6] !== 32'd0 || lg_addr[6] !== 16'd0) begin
         errs++;
         $display("FAIL ab_perf_addr got=%0d,%0d exp=0,0",
                  lg_perf[6], lg_addr[6]);
      end
      amem[0] = 32'h04030201;
      bmem[0] = 32'h01010101;
      run_tile(1, 13, -1, -1);
      checks++;
      if (m_done !== bits(11, 11) || lg_a[6][3] !== 8'h04) begin
         errs++;
         $display("FAIL ab_next_tile got=%h,%h exp=%h,04",
                  m_done, lg_a[6][3], bits(11, 11));
      end
   endtask

   task automatic test_restart();
      run_tile(4, 18, -1, 4);
      checks++;
      if (m_done !== bits(14, 14)) begin
         errs++; $display("FAIL rs_done got=%h exp=%h", m_done, bits(14, 14));
      end
      checks++;
      if (m_busy !== bits(1, 13) || m_ren !== bits(1, 4)) begin
         errs++;
         $display("FAIL rs_busy_ren got=%h,%h exp=%h,%h",
                  m_busy, m_ren, bits(1, 13), bits(1, 4));
      end
   endtask

   task automatic test_async_reset();
      for (int w = 0; w < 16; w++) begin
         amem[w] = 32'h01010101 * (w + 1);
         bmem[w] = 32'h02020202 * (w + 1);
      end
      run_tile(8, 7, -1, -1);
      checks++;
      if (lg_a[7][0] !== 8'h05 || busy !== 1'b1) begin
         errs++;
         $display("FAIL ar_pre got=%h,%b exp=05,1", lg_a[7][0], busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, pe_valid, a_ren, done, pe_clear} !== 5'b0
          || a_addr !== 16'd0) begin
         errs++;
         $display("FAIL ar_ctrl got=%b,%0d exp=0,0",
                  {busy, pe_valid, a_ren, done, pe_clear}, a_addr);
      end
      checks++;
      if ({pe_a0, pe_a1, pe_a2, pe_a3, pe_b0, pe_b1, pe_b2, pe_b3} !== 64'h0
          || perf_cycles !== 32'd0) begin
         errs++;
         $display("FAIL ar_data got=%h,%0d exp=0,0",
                  {pe_a0, pe_a1, pe_a2, pe_a3, pe_b0, pe_b1, pe_b2, pe_b3},
                  perf_cycles);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_tile(2, 14, -1, -1);
      checks++;
      if (m_done !== bits(12, 12)) begin
         errs++; $display("FAIL ar_k2_done got=%h exp=%h", m_done, bits(12, 12));
      end
      checks++;
      if (lg_perf[12] !== (PERF ? 32'd11 : 32'd0)
          || lg_perf[14] !== lg_perf[12]) begin
         errs++;
         $display("FAIL ar_k2_perf got=%0d,%0d exp=%0d",
                  lg_perf[12], lg_perf[14], PERF ? 11 : 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      k_len = '0;
      for (int w = 0; w < 16; w++) begin
         amem[w] = '0;
         bmem[w] = '0;
      end
      test_reset();
      test_k1();
      test_matmul();
      test_signed();
      test_k0();
      test_abort();
      test_restart();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
